// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side connection of the EX-stage multiply/divide unit: forwarded
// operand sources, forwarding selects, op control, and the HI/LO/status return.
interface ex_muldiv_unit_if;
    logic [31:0] ID_EX_RS_data_i;
    logic [31:0] ID_EX_RT_data_i;
    logic [31:0] EX_MEM_ALU_result_i;
    logic [31:0] MEM_WB_WriteData_i;
    logic [1:0]  forwardA_i;
    logic [1:0]  forwardB_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic        read_hilo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        done_o;
    logic        stall_o;

    modport master (
        output ID_EX_RS_data_i, ID_EX_RT_data_i, EX_MEM_ALU_result_i, MEM_WB_WriteData_i,
        output forwardA_i, forwardB_i, start_i, op_i, read_hilo_i,
        input  hi_o, lo_o, busy_o, done_o, stall_o
    );

    modport slave (
        input  ID_EX_RS_data_i, ID_EX_RT_data_i, EX_MEM_ALU_result_i, MEM_WB_WriteData_i,
        input  forwardA_i, forwardB_i, start_i, op_i, read_hilo_i,
        output hi_o, lo_o, busy_o, done_o, stall_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Sequential 32-iteration MULT/MULTU/DIV/DIVU for the EX stage, writing HI/LO,
// with operand forwarding mux and a stall request for the hazard logic.
//
// state | meaning
// IDLE  | no operation; start_i accepts operands
// RUN   | one shift-add / restoring-divide iteration per cycle, 32 cycles
// DONE  | HI/LO just written (one cycle); start_i accepts the next operation
module ex_muldiv_unit (
    input  logic              clk_i,
    input  logic              rst_i,
    ex_muldiv_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] b_mag;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        signed_in;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [31:0] iter_hi;
    logic [31:0] iter_lo;
    logic [63:0] prod;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    always_comb begin
        case (bus.forwardA_i)
            2'b10:   op_a = bus.EX_MEM_ALU_result_i;
            2'b01:   op_a = bus.MEM_WB_WriteData_i;
            default: op_a = bus.ID_EX_RS_data_i;
        endcase
        case (bus.forwardB_i)
            2'b10:   op_b = bus.EX_MEM_ALU_result_i;
            2'b01:   op_b = bus.MEM_WB_WriteData_i;
            default: op_b = bus.ID_EX_RT_data_i;
        endcase
        signed_in = ~bus.op_i[0];
        a_neg_in  = signed_in & op_a[31];
        b_neg_in  = signed_in & op_b[31];
        a_mag_in  = a_neg_in ? (32'd0 - op_a) : op_a;
        b_mag_in  = b_neg_in ? (32'd0 - op_b) : op_b;
    end

    // acc_hi/acc_lo hold {partial product, multiplier} for MULT and
    // {remainder, dividend/quotient} for DIV; both shift one bit per cycle.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_ge    = (div_shift >= {1'b0, b_mag});
        div_rem   = div_ge ? (div_shift[31:0] - b_mag) : div_shift[31:0];
        if (op_q[1]) begin
            iter_hi = div_rem;
            iter_lo = {acc_lo[30:0], div_ge};
        end else begin
            iter_hi = mul_sum[32:1];
            iter_lo = {mul_sum[0], acc_lo[31:1]};
        end
    end

    // A zero divisor yields an all-ones quotient and the dividend magnitude as
    // remainder, so restoring its sign reproduces the dividend as supplied.
    always_comb begin
        prod   = {iter_hi, iter_lo};
        hi_res = 32'd0;
        lo_res = 32'd0;
        if (op_q[1]) begin
            hi_res = a_neg ? (32'd0 - iter_hi) : iter_hi;
            if (b_mag == 32'd0)
                lo_res = 32'hFFFF_FFFF;
            else
                lo_res = (a_neg ^ b_neg) ? (32'd0 - iter_lo) : iter_lo;
        end else begin
            if (a_neg ^ b_neg)
                prod = 64'd0 - prod;
            hi_res = prod[63:32];
            lo_res = prod[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            op_q   <= 2'b00;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_mag  <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        op_q   <= bus.op_i;
                        a_neg  <= a_neg_in;
                        b_neg  <= b_neg_in;
                        b_mag  <= b_mag_in;
                        acc_hi <= 32'd0;
                        acc_lo <= a_mag_in;
                        cnt    <= 5'd0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi <= iter_hi;
                    acc_lo <= iter_lo;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        hi_q   <= hi_res;
                        lo_q   <= lo_res;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.stall_o = busy_q & (bus.read_hilo_i | bus.start_i);
endmodule
